// File: rtl/lcm_pkg.sv
// Shared constants and FSM encoding for the LCM stage that follows the GCD stage.
package lcm_pkg;

  localparam int W = 16;
  localparam logic [4:0] ITER = 5'd16;
  localparam logic [4:0] HOLD = 5'd2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_GCD = 3'd1,
    DIV      = 3'd2,
    MUL      = 3'd3,
    FINISH   = 3'd4
  } state_t;

endpackage

// File: rtl/lcm_unit_div.sv
// 16-cycle restoring divider, MSB first. The dividend register doubles as the
// quotient register: each step shifts one dividend bit out and one quotient bit in.
module restoring_div16
  import lcm_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         ready
);

  logic [W-1:0] rem;
  logic [W-1:0] dvd;
  logic [W-1:0] dsr;
  logic [4:0]   cnt;
  logic [W:0]   trial;
  logic         take;

  always_comb begin
    trial = {rem, dvd[W-1]};
    take  = (trial >= {1'b0, dsr});
  end

  // quotient and ready describe the step in flight, so the final quotient is
  // usable at the very edge that completes the last iteration.
  assign quotient = {dvd[W-2:0], take};
  assign ready    = (cnt == 5'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      dvd <= '0;
      dsr <= '0;
      cnt <= '0;
    end else if (load) begin
      rem <= '0;
      dvd <= dividend;
      dsr <= divisor;
      cnt <= ITER;
    end else if (cnt != 5'd0) begin
      // when take is set, trial - dsr < 2^W, so the low-W subtraction is exact
      rem <= trial[W-1:0] - (take ? dsr : {W{1'b0}});
      dvd <= quotient;
      cnt <= cnt - 5'd1;
    end
  end

endmodule

// File: rtl/lcm_unit.sv
// LCM stage: captures the operands at start, waits for the GCD result, then
// computes (a / gcd) * b with a divider followed by an inline shift-add multiplier.
module lcm_unit
  import lcm_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           gcd_done,
  input  logic [W-1:0]   gcd,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] lcm
);

  state_t         state, next_state;
  logic [4:0]     cnt;
  logic [W-1:0]   a_reg, b_reg;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] product;
  logic           zero_op;
  logic           div_load;
  logic           div_ready;
  logic [W-1:0]   quotient;

  restoring_div16 u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .dividend (a_reg),
    .divisor  (gcd),
    .quotient (quotient),
    .ready    (div_ready)
  );

  always_comb begin
    next_state = state;
    div_load   = 1'b0;
    zero_op    = (a_reg == '0) || (b_reg == '0) || (gcd == '0);
    case (state)
      IDLE:     if (start) next_state = WAIT_GCD;
      WAIT_GCD: if (gcd_done) begin
                  if (zero_op) begin
                    next_state = FINISH;
                  end else begin
                    next_state = DIV;
                    div_load   = 1'b1;
                  end
                end
      DIV:      if (div_ready) next_state = MUL;
      MUL:      if (cnt == ITER - 5'd1) next_state = FINISH;
      FINISH:   if (cnt == HOLD - 5'd1) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // cnt restarts on every state change and paces the MUL and FINISH states
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (state != next_state)
        cnt <= '0;
      else if (state == MUL || state == FINISH)
        cnt <= cnt + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE:     if (start) begin
                    a_reg <= a;
                    b_reg <= b;
                  end
        WAIT_GCD: if (gcd_done) product <= '0;
        DIV:      if (div_ready) begin
                    mcand   <= {{W{1'b0}}, b_reg};
                    mplier  <= quotient;
                    product <= '0;
                  end
        MUL:      begin
                    if (mplier[0]) product <= product + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                  end
        default:  ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FINISH);
  assign lcm  = done ? product : '0;

endmodule

// File: tb/tb_lcm_unit.sv
// Randomized self-checking bench for lcm_unit against an arithmetic reference
// of floor(a/g)*b with the cycle timing of the GCD-stage handshake.
module tb_lcm_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        gcd_done;
  logic [15:0] gcd;
  logic        busy, done;
  logic [31:0] lcm;

  int n_checks = 0;
  int n_fail   = 0;

  lcm_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .gcd_done (gcd_done),
    .gcd      (gcd),
    .busy     (busy),
    .done     (done),
    .lcm      (lcm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int unsigned gcd_ref(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic longint unsigned lcm_ref(input int unsigned x, input int unsigned y,
                                              input int unsigned g);
    longint unsigned q;
    if (x == 0 || y == 0 || g == 0) return 0;
    q = 64'(x / g);
    return q * 64'(y);
  endfunction

  // One full transaction: start, gap cycles in WAIT_GCD, a 2-cycle gcd_done
  // pulse, then per-cycle checks of done/lcm/busy. mid_k injects a stray start,
  // rst_k pulses reset in cycle T+rst_k, finish_start raises start in FINISH.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic [15:0] gv, input int gap,
                               input int mid_k, input int rst_k, input bit finish_start);
    longint unsigned expv;
    int lat;
    int end_k;
    bit exp_done;
    expv  = lcm_ref(av, bv, gv);
    lat   = (av == 0 || bv == 0 || gv == 0) ? 1 : 33;
    end_k = (rst_k > 0) ? rst_k + 1 : lat + 2;

    start = 1'b1;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < gap; i++) begin
      checkOutput("done_in_wait", 64'(done), 64'd0);
      tick();
    end
    gcd_done = 1'b1;
    gcd      = gv;
    tick();

    for (int k = 1; k <= end_k; k++) begin
      gcd_done = (k == 1);
      gcd      = (k == 1) ? gv : 16'($urandom);
      start    = 1'b0;
      if (k == mid_k) begin
        start = 1'b1;
        a     = 16'd1;
        b     = 16'd1;
      end
      if (finish_start && k == lat + 1) begin
        start = 1'b1;
        a     = 16'd9;
        b     = 16'd9;
      end
      if (rst_k > 0 && k == rst_k + 1) begin
        checkOutput("busy_after_rst", 64'(busy), 64'd0);
        checkOutput("done_after_rst", 64'(done), 64'd0);
        checkOutput("lcm_after_rst", 64'(lcm), 64'd0);
        break;
      end
      exp_done = (k == lat) || (k == lat + 1);
      checkOutput("done", 64'(done), 64'(exp_done));
      checkOutput("lcm", 64'(lcm), exp_done ? expv : 64'd0);
      checkOutput("busy", 64'(busy), 64'(k <= lat + 1));
      if (k == end_k) break;
      if (k == rst_k) rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    start    = 1'b0;
    gcd_done = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb, rg;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    gcd_done = 1'b0;
    gcd      = '0;
    repeat (3) tick();
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_lcm", 64'(lcm), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle_busy", 64'(busy), 64'd0);

    $display("[TB] directed cases");
    applyStimulus(16'd12, 16'd18, 16'd6, 3, 0, 0, 1'b0);
    tick();
    applyStimulus(16'd0, 16'd5, 16'd5, 2, 0, 0, 1'b0);
    tick();
    applyStimulus(16'd65535, 16'd65534, 16'd1, 1, 0, 0, 1'b0);
    tick();
    applyStimulus(16'd7, 16'd7, 16'd7, 2, 0, 0, 1'b1);
    applyStimulus(16'd21, 16'd6, 16'd3, 2, 5, 0, 1'b0);
    tick();
    applyStimulus(16'd100, 16'd75, 16'd25, 2, 0, 20, 1'b0);
    applyStimulus(16'd4, 16'd6, 16'd2, 0, 0, 0, 1'b0);
    tick();

    $display("[TB] random cases");
    for (int n = 0; n < 30; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      if ($urandom_range(0, 3) == 0)
        rg = 16'($urandom_range(1, 300));
      else
        rg = 16'(gcd_ref(32'(ra), 32'(rb)));
      applyStimulus(ra, rb, rg, $urandom_range(0, 5), 0, 0, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
